// File: rtl/hamming_encoder_stream.sv
// Byte-to-(8,4) Hamming codeword serializer: each accepted byte leaves as two
// registered codewords over a valid/ready stream, with optional error injection.
//
// state  | meaning
// IDLE   | nothing pending, ready for a byte
// FIRST  | first codeword of the byte on out_code
// SECOND | second codeword on out_code, next byte may be taken on hand-off

module hamming_encoder_stream #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        inj_en,
    input  logic [7:0]  inj_mask_first,
    input  logic [7:0]  inj_mask_second,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_code,
    output logic        out_last,
    output logic [15:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [3:0]  first_nib, second_nib;
    logic [3:0]  pend_nib;
    logic [7:0]  pend_mask;

    // bit order {p8, d3, d2, d1, p4, d0, p2, p1}; p8 makes overall parity even
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        return {^c, c};
    endfunction

    assign first_nib  = LSB_FIRST ? in_data[3:0] : in_data[7:4];
    assign second_nib = LSB_FIRST ? in_data[7:4] : in_data[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = FIRST;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state != IDLE);
    assign out_last  = (state == SECOND);

    // only the second nibble and its effective mask need to outlive acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code  <= 8'h00;
            pend_nib  <= 4'h0;
            pend_mask <= 8'h00;
            cw_count  <= 16'h0000;
        end else begin
            if (out_valid && out_ready) begin
                cw_count <= cw_count + 16'd1;
            end
            if (accept) begin
                out_code  <= encode(first_nib) ^ (inj_en ? inj_mask_first : 8'h00);
                pend_nib  <= second_nib;
                pend_mask <= inj_en ? inj_mask_second : 8'h00;
            end else if ((state == FIRST) && out_ready) begin
                out_code <= encode(pend_nib) ^ pend_mask;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream: both nibble orders side by side, checked
// against a queue of expected codewords built from the Hamming position rules.

module tb_hamming_encoder_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        inj_en = 1'b0;
    logic [7:0]  inj_mask_first = 8'h00;
    logic [7:0]  inj_mask_second = 8'h00;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, out_last1;
    logic [7:0]  out_code1;
    logic [15:0] cw_count1;
    logic        in_ready0, out_valid0, out_last0;
    logic [7:0]  out_code0;
    logic [15:0] cw_count0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       last;
    } exp_t;

    exp_t        q1[$];
    exp_t        q0[$];
    logic [15:0] exp_cnt = 16'h0000;

    always #5 clk = ~clk;

    hamming_encoder_stream #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .inj_en(inj_en), .inj_mask_first(inj_mask_first),
        .inj_mask_second(inj_mask_second), .out_valid(out_valid1), .out_ready(out_ready),
        .out_code(out_code1), .out_last(out_last1), .cw_count(cw_count1)
    );

    hamming_encoder_stream #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .inj_en(inj_en), .inj_mask_first(inj_mask_first),
        .inj_mask_second(inj_mask_second), .out_valid(out_valid0), .out_ready(out_ready),
        .out_code(out_code0), .out_last(out_last0), .cw_count(cw_count0)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classic Hamming: 1-based positions, data at non-powers-of-two, parity k
    // covers every position whose index has bit k set; bit 7 is overall parity.
    function automatic logic [7:0] ref_cw(input logic [3:0] nib);
        logic [7:0] cw;
        logic       par;
        int         dp;
        cw = 8'h00;
        dp = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[3'(pos - 1)] = nib[2'(dp)];
                dp++;
            end
        end
        for (int k = 1; k <= 4; k = k * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (((pos & k) != 0) && (pos != k)) par = par ^ cw[3'(pos - 1)];
            end
            cw[3'(k - 1)] = par;
        end
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    task automatic monitor();
        forever begin
            logic       exp_rdy;
            logic [7:0] mf, ms;
            @(negedge clk);
            if (!rst_n) begin
                q1.delete();
                q0.delete();
                exp_cnt = 16'h0000;
                chk("rst_valid", 16'(out_valid1), 16'h0);
                chk("rst_valid_msb", 16'(out_valid0), 16'h0);
                chk("rst_last", 16'(out_last1), 16'h0);
                chk("rst_code", 16'(out_code1), 16'h0);
                chk("rst_count", cw_count1, 16'h0);
                chk("rst_ready", 16'(in_ready1), 16'h1);
            end else begin
                exp_rdy = (q1.size() == 0) || ((q1.size() == 1) && out_ready);
                chk("ready", 16'(in_ready1), 16'(exp_rdy));
                chk("ready_msb", 16'(in_ready0), 16'(exp_rdy));
                chk("valid", 16'(out_valid1), 16'(q1.size() != 0));
                chk("valid_msb", 16'(out_valid0), 16'(q0.size() != 0));
                chk("count", cw_count1, exp_cnt);
                chk("count_msb", cw_count0, exp_cnt);
                if (q1.size() != 0) begin
                    chk("code", 16'(out_code1), 16'(q1[0].code));
                    chk("last", 16'(out_last1), 16'(q1[0].last));
                    chk("code_msb", 16'(out_code0), 16'(q0[0].code));
                    chk("last_msb", 16'(out_last0), 16'(q0[0].last));
                end
                if ((q1.size() != 0) && out_ready) begin
                    void'(q1.pop_front());
                    void'(q0.pop_front());
                    exp_cnt++;
                end
                if (in_valid && exp_rdy) begin
                    mf = inj_en ? inj_mask_first : 8'h00;
                    ms = inj_en ? inj_mask_second : 8'h00;
                    q1.push_back({ref_cw(in_data[3:0]) ^ mf, 1'b0});
                    q1.push_back({ref_cw(in_data[7:4]) ^ ms, 1'b1});
                    q0.push_back({ref_cw(in_data[7:4]) ^ mf, 1'b0});
                    q0.push_back({ref_cw(in_data[3:0]) ^ ms, 1'b1});
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bb[3];

    initial begin
        fork
            monitor();
        join_none

        rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset_code", 16'(out_code1), 16'h00);
        chk("reset_ready", 16'(in_ready1), 16'h1);

        // byte taken on the very first edge after release
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hF1; out_ready = 1'b1;
        cyc();
        chk("f1_first", 16'(out_code1), 16'h87);
        chk("f1_first_last", 16'(out_last1), 16'h0);
        chk("f1_hi_first_msb", 16'(out_code0), 16'hFF);
        in_valid = 1'b0;
        cyc();
        chk("f1_second", 16'(out_code1), 16'hFF);
        chk("f1_second_last", 16'(out_last1), 16'h1);
        chk("f1_lo_second_msb", 16'(out_code0), 16'h87);
        cyc();
        chk("f1_done_valid", 16'(out_valid1), 16'h0);
        chk("f1_count", cw_count1, 16'd2);

        in_valid = 1'b1; in_data = 8'h30;
        cyc();
        chk("msb_30_first", 16'(out_code0), 16'h1E);
        in_data = 8'h00;
        cyc();
        chk("msb_30_second", 16'(out_code0), 16'h00);
        chk("msb_30_second_last", 16'(out_last0), 16'h1);
        cyc();
        chk("msb_00_first", 16'(out_code0), 16'h00);
        chk("msb_00_first_last", 16'(out_last0), 16'h0);
        in_valid = 1'b0;
        cyc();
        chk("msb_00_second", 16'(out_code0), 16'h00);
        cyc();

        in_valid = 1'b1; in_data = 8'h00; inj_en = 1'b1;
        inj_mask_first = 8'h80; inj_mask_second = 8'h24;
        cyc();
        chk("inj_first", 16'(out_code1), 16'h80);
        inj_en = 1'b0;
        cyc();
        chk("inj_second", 16'(out_code1), 16'h24);
        cyc();
        chk("noinj_first", 16'(out_code1), 16'h00);
        in_valid = 1'b0;
        cyc();
        chk("noinj_second", 16'(out_code1), 16'h00);
        cyc();
        inj_mask_first = 8'h00; inj_mask_second = 8'h00;

        bb[0] = 8'h01; bb[1] = 8'hF1; bb[2] = 8'h10;
        in_valid = 1'b1; in_data = bb[0];
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("b2b_first_valid", 16'(out_valid1), 16'h1);
            chk("b2b_first_ready", 16'(in_ready1), 16'h0);
            chk("b2b_first_code", 16'(out_code1), 16'(ref_cw(bb[i][3:0])));
            if (i < 2) in_data = bb[i + 1];
            else in_valid = 1'b0;
            cyc();
            chk("b2b_second_valid", 16'(out_valid1), 16'h1);
            chk("b2b_second_ready", 16'(in_ready1), 16'h1);
            chk("b2b_second_code", 16'(out_code1), 16'(ref_cw(bb[i][7:4])));
        end
        cyc();

        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        in_data = 8'h5A; inj_en = 1'b1; inj_mask_first = 8'hFF; inj_mask_second = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_code", 16'(out_code1), 16'h2D);
            chk("stall_valid", 16'(out_valid1), 16'h1);
            chk("stall_last", 16'(out_last1), 16'h0);
            chk("stall_count", cw_count1, 16'd16);
        end
        out_ready = 1'b1; inj_en = 1'b0;
        cyc();
        chk("stall_release_code", 16'(out_code1), 16'hD2);
        chk("stall_release_count", cw_count1, 16'd17);
        cyc();
        chk("stall_done_count", cw_count1, 16'd18);

        for (int i = 0; i < 400; i++) begin
            in_valid        = 1'($urandom_range(0, 1));
            in_data         = 8'($urandom);
            inj_en          = ($urandom_range(0, 3) == 0);
            inj_mask_first  = 8'($urandom);
            inj_mask_second = 8'($urandom);
            out_ready       = ($urandom_range(0, 3) != 0);
            cyc();
        end

        in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("mid_second_last", 16'(out_last1), 16'h1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(out_valid1), 16'h0);
        chk("async_rst_count", cw_count1, 16'h0);
        chk("async_rst_ready", 16'(in_ready1), 16'h1);
        chk("async_rst_last", 16'(out_last1), 16'h0);
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        chk("post_rst_valid", 16'(out_valid1), 16'h0);
        cyc();
        chk("post_rst_valid2", 16'(out_valid1), 16'h0);
        chk("post_rst_count", cw_count1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_stream.md
HAMMING_ENCODER_STREAM -- requirements
Module: hamming_encoder_stream

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = low nibble sent first, 0 = high nibble sent first.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  byte present on in_data.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 in_data  input  8  byte to encode.
REQ-008 inj_en  input  1  apply error-injection masks to this byte.
REQ-009 inj_mask_first  input  8  XOR mask for first codeword.
REQ-010 inj_mask_second  input  8  XOR mask for second codeword.
REQ-011 out_valid  output  1  codeword present on out_code.
REQ-012 out_ready  input  1  downstream (hamming_decoder side) accepts codeword.
REQ-013 out_code  output  8  (8,4) codeword, registered.
REQ-014 out_last  output  1  high while out_code holds the second codeword of a byte.
REQ-015 cw_count  output  16  count of codewords handed off.

Function
REQ-016 Codeword layout SHALL be: bit0 p1, bit1 p2, bit2 d0, bit3 p4, bit4 d1, bit5 d2, bit6 d3, bit7 p8.
REQ-017 Parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3, p8=XOR of bits 6:0 (even overall parity).
REQ-018 FSM states SHALL be IDLE, FIRST, SECOND; reset state IDLE.
REQ-019 IDLE: out_valid=0, in_ready=1; on in_valid -> capture in_data, inj_en, both masks; load out_code with the first codeword; go FIRST.
REQ-020 FIRST: out_valid=1, out_last=0, in_ready=0; on out_ready -> load out_code with the second codeword; go SECOND.
REQ-021 SECOND: out_valid=1, out_last=1, in_ready=out_ready; on out_ready with in_valid -> capture the new byte, load its first codeword, go FIRST; on out_ready without in_valid -> go IDLE, out_valid=0.
REQ-022 Sustained throughput SHALL be one byte per two cycles with no bubble.
REQ-023 First codeword SHALL be valid the cycle after byte acceptance (latency 1).
REQ-024 The first codeword is the low nibble when LSB_FIRST=1 and the high nibble when LSB_FIRST=0.
REQ-025 Injected codeword = encoded codeword XOR mask, applied only if inj_en was high at acceptance; masks are latched and never applied to later bytes.
REQ-026 out_code and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 cw_count SHALL increment by 1 on every out_valid&out_ready cycle and wrap 0xFFFF -> 0x0000.
REQ-028 in_data and mask changes while in_ready=0 SHALL have no effect.
REQ-029 in_ready SHALL be a function of state and out_ready only, never of in_valid.

Reset
REQ-030 While rst_n=0: state IDLE, out_valid=0, out_code=0x00, out_last=0, cw_count=0, in_ready=1, latched byte/masks cleared.
REQ-031 Reset asserted mid-byte (FIRST or SECOND) SHALL discard the byte; no partial codeword appears after release.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 LSB_FIRST=1, in_data=0xF1, out_ready=1 -> out_code 0x87 (out_last=0), then 0xFF (out_last=1); cw_count=2.
REQ-034 LSB_FIRST=0, in_data=0x30 -> out_code 0x1E, then 0x00; in_data=0x00 -> 0x00, 0x00.
REQ-035 in_data=0x00, inj_en=1, masks 0x80/0x24 -> out_code 0x80, then 0x24; the next byte 0x00 with inj_en=0 -> 0x00, 0x00.
REQ-036 Back-to-back bytes 0x01, 0xF1, 0x10 with in_valid and out_ready held high -> six consecutive valid codewords with no gap, and in_ready high only in SECOND cycles.
REQ-037 out_ready low for 3 cycles in FIRST -> out_code and out_valid held unchanged, and cw_count unchanged until release.
REQ-038 rst_n pulsed low in SECOND -> out_valid=0 and cw_count=0 immediately (asynchronously), and in_ready=1.
